// File: rtl/max7219_pkg.sv
// ============================================================================
// Module   : max7219_pkg
// Purpose  : Shared constants, FSM encoding and register record for max7219_rx
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package max7219_pkg;

  localparam int c_DATABITS_DEF = 16;

  localparam logic [3:0] c_ADDR_NOOP      = 4'h0;
  localparam logic [3:0] c_ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] c_ADDR_DIGIT7    = 4'h8;
  localparam logic [3:0] c_ADDR_DECODE    = 4'h9;
  localparam logic [3:0] c_ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] c_ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] c_ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] c_ADDR_TEST      = 4'hF;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RECV = 1'b1;

  typedef struct packed {
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        display_test;
  } max7219_regs_t;

  // Digit registers live at addresses 1..8 and map to digit slots 0..7.
  function automatic logic [2:0] digit_index(input logic [3:0] addr);
    return 3'(addr - c_ADDR_DIGIT0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Purpose  : Multi-flop synchronizer with registered rise/fall pulse outputs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,    // active-low, asynchronous
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  // Pulses are registered so that the downstream frame strobe lands exactly
  // SYNC_STAGES+2 clocks after the pin transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign q    = r_sync[SYNC_STAGES-1];
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/max7219_rx.sv
// ============================================================================
// Module   : max7219_rx
// Purpose  : Oversampled SPI receiver emulating the MAX7219 register file
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module max7219_rx
  import max7219_pkg::*;
#(
  parameter int DATABITS    = c_DATABITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                sclk,
  input  logic                din,
  output logic                busy,
  output logic [DATABITS-1:0] frame,
  output logic                frame_valid,
  output logic                frame_err,
  output logic [63:0]         digits,
  output logic [7:0]          decode_mode,
  output logic [3:0]          intensity,
  output logic [2:0]          scan_limit,
  output logic                shutdown_n,
  output logic                display_test
);

  localparam int                 c_CNT_W    = $clog2(DATABITS + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATABITS);
  localparam logic [c_CNT_W-1:0] c_CNT_OVF  = c_CNT_W'(DATABITS + 1);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic                   w_cs_s;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_sclk_s;
  logic                   w_sclk_rise;
  logic                   w_unused_sclk_fall;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   w_din_s;

  logic [0:0]             r_state;
  logic [DATABITS-1:0]    r_shreg;
  logic [c_CNT_W-1:0]     r_bitcnt;
  logic [DATABITS-1:0]    r_frame;
  logic                   r_frame_valid;
  logic                   r_frame_err;
  max7219_regs_t          r_regs;

  logic                   w_cs_end;
  logic                   w_commit;
  logic [3:0]             w_addr;
  logic [7:0]             w_data;

  // Reset asserts immediately and releases synchronously to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk (clk),
    .rst (w_rst_n),
    .d   (cs),
    .q   (w_cs_s),
    .rise(w_cs_rise),
    .fall(w_cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk (clk),
    .rst (w_rst_n),
    .d   (sclk),
    .q   (w_sclk_s),
    .rise(w_sclk_rise),
    .fall(w_unused_sclk_fall)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_din_sync <= '0;
    else          r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
  end
  assign w_din_s = r_din_sync[SYNC_STAGES-1];

  assign w_cs_end = (r_state == c_ST_RECV) && w_cs_rise;
  assign w_commit = w_cs_end && (r_bitcnt == c_CNT_FULL);
  assign w_addr   = r_shreg[11:8];
  assign w_data   = r_shreg[7:0];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= c_ST_IDLE;
      r_shreg       <= '0;
      r_bitcnt      <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_cs_fall) begin
            r_state  <= c_ST_RECV;
            r_shreg  <= '0;
            r_bitcnt <= '0;
          end
        end
        c_ST_RECV: begin
          // cs rise wins over a coincident sclk rise: that last edge is dropped.
          if (w_cs_end) begin
            r_state <= c_ST_IDLE;
            if (w_commit) begin
              r_frame       <= r_shreg;
              r_frame_valid <= 1'b1;
            end else begin
              r_frame_err   <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_shreg <= {r_shreg[DATABITS-2:0], w_din_s};
            if (r_bitcnt != c_CNT_OVF) r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_regs <= '0;
    end else if (w_commit) begin
      if (w_addr >= c_ADDR_DIGIT0 && w_addr <= c_ADDR_DIGIT7) begin
        r_regs.digits[{digit_index(w_addr), 3'b000} +: 8] <= w_data;
      end else begin
        case (w_addr)
          c_ADDR_NOOP:      ;
          c_ADDR_DECODE:    r_regs.decode_mode  <= w_data;
          c_ADDR_INTENSITY: r_regs.intensity    <= w_data[3:0];
          c_ADDR_SCANLIMIT: r_regs.scan_limit   <= w_data[2:0];
          c_ADDR_SHUTDOWN:  r_regs.shutdown_n   <= w_data[0];
          c_ADDR_TEST:      r_regs.display_test <= w_data[0];
          default:          ;
        endcase
      end
    end
  end

  assign busy         = ~w_cs_s;
  assign frame        = r_frame;
  assign frame_valid  = r_frame_valid;
  assign frame_err    = r_frame_err;
  assign digits       = r_regs.digits;
  assign decode_mode  = r_regs.decode_mode;
  assign intensity    = r_regs.intensity;
  assign scan_limit   = r_regs.scan_limit;
  assign shutdown_n   = r_regs.shutdown_n;
  assign display_test = r_regs.display_test;

endmodule

`default_nettype wire

// File: tb/tb_max7219_rx.sv
// ============================================================================
// Module   : tb_max7219_rx
// Purpose  : Self-checking bench for max7219_rx (table, random and corner cases)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_max7219_rx;

  localparam int c_SYNC    = 2;
  localparam int c_LATENCY = c_SYNC + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        din = 1'b0;
  logic        busy;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_err;
  logic [63:0] digits;
  logic [7:0]  decode_mode;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;
  logic        shutdown_n;
  logic        display_test;

  max7219_rx #(.DATABITS(16), .SYNC_STAGES(c_SYNC)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .din(din), .busy(busy),
    .frame(frame), .frame_valid(frame_valid), .frame_err(frame_err),
    .digits(digits), .decode_mode(decode_mode), .intensity(intensity),
    .scan_limit(scan_limit), .shutdown_n(shutdown_n), .display_test(display_test)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int pulse_cyc = 0;
  int cs_rise_cyc = 0;

  // Reference model: the MAX7219 register file as plain variables.
  logic [7:0]  m_dig [8];
  logic [7:0]  m_dec;
  logic [3:0]  m_int;
  logic [2:0]  m_scan;
  logic        m_shut;
  logic        m_test;
  logic [15:0] m_frame;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (frame_valid) begin n_valid++; pulse_cyc = cyc; end
    if (frame_err)   begin n_err++;   pulse_cyc = cyc; end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
    m_dec = 8'h00; m_int = 4'h0; m_scan = 3'h0; m_shut = 1'b0; m_test = 1'b0;
    m_frame = 16'h0000;
  endfunction

  function automatic void m_apply(input logic [15:0] f);
    int a;
    a = int'(f[11:8]);
    m_frame = f;
    if (a >= 1 && a <= 8) m_dig[a-1] = f[7:0];
    else if (a == 9)  m_dec  = f[7:0];
    else if (a == 10) m_int  = f[3:0];
    else if (a == 11) m_scan = f[2:0];
    else if (a == 12) m_shut = f[0];
    else if (a == 15) m_test = f[0];
  endfunction

  task automatic chk_regs(input string tag);
    logic [63:0] ed;
    for (int i = 0; i < 8; i++) ed[8*i +: 8] = m_dig[i];
    chk({tag, ".digits"}, digits, ed);
    chk({tag, ".decode"}, 64'(decode_mode), 64'(m_dec));
    chk({tag, ".intensity"}, 64'(intensity), 64'(m_int));
    chk({tag, ".scan"}, 64'(scan_limit), 64'(m_scan));
    chk({tag, ".shutdown_n"}, 64'(shutdown_n), 64'(m_shut));
    chk({tag, ".test"}, 64'(display_test), 64'(m_test));
    chk({tag, ".frame"}, 64'(frame), 64'(m_frame));
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nbits of val MSB first; when clash is set the final sclk rise is
  // driven in the same instant as cs rise.
  task automatic send_bits(input logic [31:0] val, input int nbits, input int half,
                           input bit clash);
    cs = 1'b0;
    wait_clk(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      din = val[i];
      wait_clk(half);
      if (clash && i == 0) break;
      sclk = 1'b1;
      wait_clk(half);
      sclk = 1'b0;
    end
    if (!clash) wait_clk(half);
    cs = 1'b1;
    if (clash) sclk = 1'b1;
    cs_rise_cyc = cyc;
    wait_clk(half);
    sclk = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] val, input int nbits,
                           input int half, input bit clash);
    bit ok;
    ok = (nbits == 16) && !clash;
    n_valid = 0; n_err = 0; pulse_cyc = -1;
    send_bits(val, nbits, half, clash);
    wait_clk(c_LATENCY + 6);
    chk({tag, ".n_valid"}, 64'(n_valid), ok ? 64'd1 : 64'd0);
    chk({tag, ".n_err"}, 64'(n_err), ok ? 64'd0 : 64'd1);
    chk({tag, ".latency"}, 64'(pulse_cyc - cs_rise_cyc), 64'(c_LATENCY));
    if (ok) m_apply(val[15:0]);
    chk_regs(tag);
    wait_clk(c_LATENCY + 2);
  endtask

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic        exp_valid;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h0A07,  16, 1'b1, 16'h0A07};
    tbl[1] = '{32'h0155,  16, 1'b1, 16'h0155};
    tbl[2] = '{32'h08AA,  16, 1'b1, 16'h08AA};
    tbl[3] = '{32'h0C01,  16, 1'b1, 16'h0C01};
    tbl[4] = '{32'h0B05,  16, 1'b1, 16'h0B05};
    tbl[5] = '{32'h1234,  15, 1'b0, 16'h0B05};
    tbl[6] = '{32'h1ABCD, 17, 1'b0, 16'h0B05};
    tbl[7] = '{32'hF90F,  16, 1'b1, 16'hF90F};
    tbl[8] = '{32'h0D33,  16, 1'b1, 16'h0D33};
    tbl[9] = '{32'h0F01,  16, 1'b1, 16'h0F01};

    m_reset();
    rst = 1'b0;
    wait_clk(5);
    rst = 1'b1;
    n_valid = 0; n_err = 0;
    wait_clk(100);
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.pulses", 64'(n_valid + n_err), 64'd0);
    chk_regs("reset");

    for (int i = 0; i < 10; i++) begin
      n_valid = 0; n_err = 0;
      send_bits(tbl[i].data, tbl[i].nbits, 50, 1'b0);
      wait_clk(c_LATENCY + 6);
      chk($sformatf("tbl%0d.valid", i), 64'(n_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.err", i), 64'(n_err), 64'(!tbl[i].exp_valid));
      chk($sformatf("tbl%0d.frame", i), 64'(frame), 64'(tbl[i].exp_frame));
      chk($sformatf("tbl%0d.latency", i), 64'(pulse_cyc - cs_rise_cyc), 64'(c_LATENCY));
      if (tbl[i].exp_valid) m_apply(tbl[i].data[15:0]);
      chk_regs($sformatf("tbl%0d", i));
      wait_clk(10);
    end

    chk("plan.digit0", 64'(digits[7:0]), 64'h55);
    chk("plan.digit7", 64'(digits[63:56]), 64'hAA);
    chk("plan.shutdown_n", 64'(shutdown_n), 64'd1);
    chk("plan.scan", 64'(scan_limit), 64'd5);
    chk("plan.decode", 64'(decode_mode), 64'h0F);
    chk("plan.intensity", 64'(intensity), 64'd7);

    // sclk toggling while deselected must not disturb anything.
    n_valid = 0; n_err = 0;
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1; wait_clk(6); sclk = 1'b0; wait_clk(6);
    end
    wait_clk(10);
    chk("idle_sclk.pulses", 64'(n_valid + n_err), 64'd0);
    chk_regs("idle_sclk");

    // 16th sclk rise coincides with cs rise: dropped, so the frame is short.
    run_frame("clash", 32'h0A03, 16, 8, 1'b1);

    // busy follows cs with synchronizer delay.
    cs = 1'b0;
    wait_clk(c_SYNC + 2);
    chk("busy.high", 64'(busy), 64'd1);
    cs = 1'b1;
    wait_clk(c_SYNC + 2);
    chk("busy.low", 64'(busy), 64'd0);
    wait_clk(10);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] v;
      int nb;
      int r;
      v  = $urandom();
      r  = int'($urandom_range(0, 9));
      nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      run_frame($sformatf("rnd%0d", k), v & 32'h1FFFF, nb, int'($urandom_range(5, 8)), 1'b0);
    end

    // Reset mid-frame, release with cs still low, then finish the frame.
    n_valid = 0; n_err = 0;
    cs = 1'b0;
    wait_clk(20);
    for (int i = 15; i >= 8; i--) begin
      din = 1'(i & 1); wait_clk(20); sclk = 1'b1; wait_clk(20); sclk = 1'b0;
    end
    rst = 1'b0;
    #1;
    m_reset();
    chk("midrst.async_digits", digits, 64'h0);
    wait_clk(4);
    rst = 1'b1;
    wait_clk(20);
    chk("midrst.busy", 64'(busy), 64'd1);
    for (int i = 7; i >= 0; i--) begin
      din = 1'(i & 1); wait_clk(20); sclk = 1'b1; wait_clk(20); sclk = 1'b0;
    end
    wait_clk(20);
    cs = 1'b1;
    wait_clk(c_LATENCY + 6);
    chk("midrst.n_valid", 64'(n_valid), 64'd0);
    chk("midrst.n_err", 64'(n_err), 64'd1);
    chk_regs("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
